rt_dmem_arbiter: RTL and testbench
==================================

Name: rt_dmem_arbiter

Overview:
- Two-port arbiter that shares the single-port data memory between the RT-core and the application core (AP-core) of the MAKu dual-core MCU.
- Each requester side matches the core dmem interface: en/we/addr/wdata/rdata/ready. The core holds its request while ready is low.
- RT-core has fixed priority. A bounded-starvation counter guarantees AP-core progress and a deterministic RT worst-case latency.

Parameters:
- AP_MAX_WAIT, 4, number of arbitrations the AP may lose before it is forced to win; legal range >= 1.
- TIMEOUT_CYC, 64, cycles in a GRANT state without mem_ready before abort; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rt_en / rt_we  in  1 / 1  RT request valid / write
- rt_addr / rt_wdata  in  32 / 32  RT address / write data
- rt_rdata / rt_ready  out  32 / 1  RT read data / completion strobe
- ap_en / ap_we / ap_addr / ap_wdata  in  1/1/32/32  AP request, same meaning as the RT fields
- ap_rdata / ap_ready  out  32 / 1  AP read data / completion strobe
- mem_en / mem_we  out  1 / 1  memory request / write
- mem_addr / mem_wdata  out  32 / 32  memory address / write data
- mem_rdata / mem_ready  in  32 / 1  memory read data / completion
- rt_grant / ap_grant  out  1 / 1  current owner, for debug
- timeout_err  out  1  one-cycle abort pulse; tied 0 when the optional feature is absent

Behaviour:
- Reset (async): state=IDLE; all outputs 0; latched request regs 0; ap_wait_cnt=0.
- States: IDLE, GRANT_RT, GRANT_AP.
- IDLE arbitration, evaluated every IDLE cycle:
  - If ap_en and ap_wait_cnt >= AP_MAX_WAIT: go to GRANT_AP.
  - Else if rt_en: go to GRANT_RT.
  - Else if ap_en: go to GRANT_AP.
  - Else stay in IDLE.
- Request latch: on the transition into a GRANT state, latch the winner's we/addr/wdata. Requester input changes during the grant are ignored.
- GRANT_x outputs:
  - mem_en=1; mem_we/mem_addr/mem_wdata come from the latch.
  - x_grant=1.
  - x_rdata = mem_rdata, combinational pass-through.
  - x_ready = mem_ready, combinational.
- Completion: in the cycle where mem_ready=1, deassert mem_en next cycle and return to IDLE. There is one idle turnaround cycle between accesses, even with back-to-back requests.
- Non-owner: ready=0 and rdata=0 at all times. Ready is never asserted without an active grant.
- ap_wait_cnt:
  - Increments (saturating at AP_MAX_WAIT) on each IDLE arbitration where ap_en=1 and RT wins.
  - Clears on entry to GRANT_AP.
  - Holds otherwise.
- Latency: request visible in IDLE at cycle N gives mem_en at N+1 and earliest ready at N+1 (zero-wait memory).
- RT worst case, with AP_MAX_WAIT forcing a loss: one AP access (1 + mem latency), plus 1 IDLE cycle, plus its own access.
- Requester drops en while not granted: no effect, no grant issued.
- Reset mid-grant: immediate IDLE, mem_en=0, and the in-flight access is abandoned (the memory must also be reset).
- mem_ready asserted in IDLE: ignored.

Optional Feature:
- Macro: MAKU_DMEM_ARB_TIMEOUT_EN.
- With the macro:
  - A counter runs in each GRANT state.
  - If it reaches TIMEOUT_CYC with no mem_ready, the owner gets x_ready=1 with x_rdata=32'hDEAD_BEEF for one cycle.
  - timeout_err pulses for 1 cycle, mem_en drops, and the state returns to IDLE.
  - The counter clears on every GRANT entry.
- Without the macro: the arbiter waits indefinitely for mem_ready, and timeout_err=0.

Test Plan:
- RT read 0x100, mem_ready 2 cycles after mem_en, mem_rdata=0x12345678 -> rt_grant N+1..N+3, rt_ready=1 and rt_rdata=0x12345678 at N+3, IDLE at N+4.
- rt_en and ap_en rise together, zero-wait memory -> RT served first, then AP granted at the next IDLE arbitration; ap_wait_cnt goes to 1, then 0.
- RT requests continuously, AP holds ap_en, AP_MAX_WAIT=4 -> exactly 4 RT grants, then a GRANT_AP; rt_ready stays 0 during the AP access.
- AP write in flight (mem_ready delayed 3 cycles) when RT asserts -> RT waits, mem_addr and mem_wdata stay at the AP latch values, and RT is granted one IDLE cycle after ap_ready.
- rst_n pulsed low during GRANT_RT -> mem_en, rt_ready and rt_grant go 0 asynchronously; after release, state is IDLE with ap_wait_cnt=0.
- With MAKU_DMEM_ARB_TIMEOUT_EN, TIMEOUT_CYC=8, mem_ready held 0 -> after 8 granted cycles: rt_ready=1, rt_rdata=0xDEADBEEF, timeout_err 1-cycle pulse.

Source files
------------

// File: rtl/rt_dmem_arbiter.sv
// Shares the single-port data memory between the RT-core (fixed priority) and the AP-core (bounded starvation).
// Optional grant timeout is enabled by defining MAKU_DMEM_ARB_TIMEOUT_EN.
module rt_dmem_arbiter #(
  parameter int unsigned AP_MAX_WAIT = 4,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rt_en,
  input  logic        rt_we,
  input  logic [31:0] rt_addr,
  input  logic [31:0] rt_wdata,
  output logic [31:0] rt_rdata,
  output logic        rt_ready,
  input  logic        ap_en,
  input  logic        ap_we,
  input  logic [31:0] ap_addr,
  input  logic [31:0] ap_wdata,
  output logic [31:0] ap_rdata,
  output logic        ap_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        rt_grant,
  output logic        ap_grant,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, GRANT_RT, GRANT_AP} state_t;

  localparam int unsigned CW = $clog2(AP_MAX_WAIT + 1);

  state_t        state;
  logic [CW-1:0] ap_wait_cnt;
  logic          ap_forced;
  logic          to_hit;
  logic          done;

  assign ap_forced = (ap_wait_cnt >= CW'(AP_MAX_WAIT));

`ifdef MAKU_DMEM_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt;

  // Fires on the TIMEOUT_CYC-th granted cycle that still has no mem_ready.
  assign to_hit      = (state != IDLE) && !mem_ready && (to_cnt == TW'(TIMEOUT_CYC - 1));
  assign timeout_err = to_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state == IDLE || done) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg  = ^TIMEOUT_CYC;
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign done = (state != IDLE) && (mem_ready || to_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ap_wait_cnt <= '0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      rt_grant    <= 1'b0;
      ap_grant    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ap_en && ap_forced) begin
            state       <= GRANT_AP;
            ap_wait_cnt <= '0;
            mem_en      <= 1'b1;
            mem_we      <= ap_we;
            mem_addr    <= ap_addr;
            mem_wdata   <= ap_wdata;
            ap_grant    <= 1'b1;
          end else if (rt_en) begin
            state     <= GRANT_RT;
            mem_en    <= 1'b1;
            mem_we    <= rt_we;
            mem_addr  <= rt_addr;
            mem_wdata <= rt_wdata;
            rt_grant  <= 1'b1;
            // ap_en here implies the counter is below AP_MAX_WAIT, so this saturates.
            if (ap_en) ap_wait_cnt <= ap_wait_cnt + 1'b1;
          end else if (ap_en) begin
            state       <= GRANT_AP;
            ap_wait_cnt <= '0;
            mem_en      <= 1'b1;
            mem_we      <= ap_we;
            mem_addr    <= ap_addr;
            mem_wdata   <= ap_wdata;
            ap_grant    <= 1'b1;
          end
        end
        default: begin
          if (done) begin
            state    <= IDLE;
            mem_en   <= 1'b0;
            rt_grant <= 1'b0;
            ap_grant <= 1'b0;
          end
        end
      endcase
    end
  end

  always_comb begin
    rt_ready = rt_grant && (mem_ready || to_hit);
    ap_ready = ap_grant && (mem_ready || to_hit);
    rt_rdata = '0;
    ap_rdata = '0;
    if (rt_grant) rt_rdata = to_hit ? 32'hDEAD_BEEF : mem_rdata;
    if (ap_grant) ap_rdata = to_hit ? 32'hDEAD_BEEF : mem_rdata;
  end

endmodule

// File: tb/tb_rt_dmem_arbiter.sv
// Directed self-checking bench for rt_dmem_arbiter with a latency-programmable memory responder.
module tb_rt_dmem_arbiter;

  logic        clk, rst_n;
  logic        rt_en, rt_we, ap_en, ap_we;
  logic [31:0] rt_addr, rt_wdata, ap_addr, ap_wdata;
  logic [31:0] rt_rdata, ap_rdata;
  logic        rt_ready, ap_ready;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;
  logic        rt_grant, ap_grant, timeout_err;

  logic [3:0]  mem_lat, wcnt;
  logic [31:0] rd_val;
  logic        ready_force;
  int          n_pass, n_total;

  rt_dmem_arbiter #(.AP_MAX_WAIT(4), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .rt_en(rt_en), .rt_we(rt_we), .rt_addr(rt_addr), .rt_wdata(rt_wdata),
    .rt_rdata(rt_rdata), .rt_ready(rt_ready),
    .ap_en(ap_en), .ap_we(ap_we), .ap_addr(ap_addr), .ap_wdata(ap_wdata),
    .ap_rdata(ap_rdata), .ap_ready(ap_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .rt_grant(rt_grant), .ap_grant(ap_grant), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory answers mem_lat cycles after mem_en first goes high.
  assign mem_ready = ready_force | (mem_en && (wcnt == mem_lat));
  assign mem_rdata = mem_ready ? rd_val : '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   wcnt <= '0;
    else if (mem_en && !mem_ready) wcnt <= wcnt + 1'b1;
    else                          wcnt <= '0;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_total++; if (mem_en !== 1'b0) $display("FAIL reset_mem_en got %b exp 0", mem_en); else n_pass++;
    n_total++; if ({rt_grant, ap_grant} !== 2'b00) $display("FAIL reset_grants got %b exp 00", {rt_grant, ap_grant}); else n_pass++;
    n_total++; if ({rt_ready, ap_ready, timeout_err} !== 3'b000) $display("FAIL reset_ready got %b exp 000", {rt_ready, ap_ready, timeout_err}); else n_pass++;
    n_total++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr got %h exp 0", mem_addr); else n_pass++;
    step(); step();
    rst_n = 1'b1;
    step();
    n_total++; if (mem_en !== 1'b0) $display("FAIL post_reset_idle got %b exp 0", mem_en); else n_pass++;
  endtask

  task automatic test_rt_read();
    mem_lat = 4'd2; rd_val = 32'h1234_5678;
    rt_en = 1'b1; rt_we = 1'b0; rt_addr = 32'h100;
    step(); // N+1
    n_total++; if ({mem_en, rt_grant, mem_we} !== 3'b110) $display("FAIL rt_read_grant got %b exp 110", {mem_en, rt_grant, mem_we}); else n_pass++;
    n_total++; if (mem_addr !== 32'h100) $display("FAIL rt_read_addr got %h exp 00000100", mem_addr); else n_pass++;
    n_total++; if (rt_ready !== 1'b0) $display("FAIL rt_read_early_ready N+1 got %b exp 0", rt_ready); else n_pass++;
    step(); // N+2
    n_total++; if ({rt_grant, rt_ready} !== 2'b10) $display("FAIL rt_read_wait N+2 got %b exp 10", {rt_grant, rt_ready}); else n_pass++;
    step(); // N+3
    n_total++; if ({rt_grant, rt_ready} !== 2'b11) $display("FAIL rt_read_ready N+3 got %b exp 11", {rt_grant, rt_ready}); else n_pass++;
    n_total++; if (rt_rdata !== 32'h1234_5678) $display("FAIL rt_read_rdata got %h exp 12345678", rt_rdata); else n_pass++;
    n_total++; if ({ap_ready, ap_rdata} !== 33'h0) $display("FAIL rt_read_ap_quiet got %b/%h exp 0/0", ap_ready, ap_rdata); else n_pass++;
    rt_en = 1'b0;
    step(); // N+4
    n_total++; if ({mem_en, rt_grant, rt_ready} !== 3'b000) $display("FAIL rt_read_idle N+4 got %b exp 000", {mem_en, rt_grant, rt_ready}); else n_pass++;
  endtask

  task automatic test_simultaneous();
    mem_lat = 4'd0; rd_val = 32'hA5A5_0001;
    rt_en = 1'b1; rt_addr = 32'h10; ap_en = 1'b1; ap_we = 1'b0; ap_addr = 32'h20;
    step();
    n_total++; if ({rt_grant, ap_grant, rt_ready} !== 3'b101) $display("FAIL simul_rt_first got %b exp 101", {rt_grant, ap_grant, rt_ready}); else n_pass++;
    n_total++; if (dut.ap_wait_cnt !== 3'd1) $display("FAIL simul_wait_cnt_1 got %0d exp 1", dut.ap_wait_cnt); else n_pass++;
    rt_en = 1'b0;
    step();
    n_total++; if ({mem_en, ap_grant} !== 2'b00) $display("FAIL simul_turnaround got %b exp 00", {mem_en, ap_grant}); else n_pass++;
    step();
    n_total++; if ({ap_grant, ap_ready, rt_grant} !== 3'b110) $display("FAIL simul_ap_second got %b exp 110", {ap_grant, ap_ready, rt_grant}); else n_pass++;
    n_total++; if (mem_addr !== 32'h20) $display("FAIL simul_ap_addr got %h exp 00000020", mem_addr); else n_pass++;
    n_total++; if (ap_rdata !== 32'hA5A5_0001) $display("FAIL simul_ap_rdata got %h exp a5a50001", ap_rdata); else n_pass++;
    n_total++; if (dut.ap_wait_cnt !== 3'd0) $display("FAIL simul_wait_cnt_0 got %0d exp 0", dut.ap_wait_cnt); else n_pass++;
    ap_en = 1'b0;
    step();
  endtask

  task automatic test_starvation();
    int  rt_grants;
    bit  seen;
    rt_grants = 0; seen = 1'b0;
    mem_lat = 4'd0;
    rt_en = 1'b1; rt_addr = 32'h40; ap_en = 1'b1; ap_addr = 32'h80;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (ap_grant) begin
        seen = 1'b1;
        n_total++; if ({rt_ready, rt_grant, ap_ready} !== 3'b001) $display("FAIL starve_ap_access got %b exp 001", {rt_ready, rt_grant, ap_ready}); else n_pass++;
        rt_en = 1'b0; ap_en = 1'b0;
      end else if (rt_grant) begin
        rt_grants++;
      end
    end
    n_total++; if (seen !== 1'b1) $display("FAIL starve_ap_granted got %b exp 1 (cycle budget)", seen); else n_pass++;
    n_total++; if (rt_grants != 4) $display("FAIL starve_rt_count got %0d exp 4", rt_grants); else n_pass++;
    step();
    n_total++; if (dut.ap_wait_cnt !== 3'd0) $display("FAIL starve_wait_cleared got %0d exp 0", dut.ap_wait_cnt); else n_pass++;
  endtask

  task automatic test_ap_write_inflight();
    bit got;
    got = 1'b0;
    mem_lat = 4'd3;
    ap_en = 1'b1; ap_we = 1'b1; ap_addr = 32'h200; ap_wdata = 32'hCAFE_F00D;
    step(); // K+1
    n_total++; if ({ap_grant, mem_we} !== 2'b11) $display("FAIL apw_grant got %b exp 11", {ap_grant, mem_we}); else n_pass++;
    rt_en = 1'b1; rt_we = 1'b0; rt_addr = 32'h300;
    ap_addr = 32'h999; ap_wdata = 32'h0BAD_0BAD;
    for (int i = 0; i < 2; i++) begin
      step();
      n_total++; if ({mem_addr, mem_wdata} !== {32'h200, 32'hCAFE_F00D}) $display("FAIL apw_latch got %h/%h exp 00000200/cafef00d", mem_addr, mem_wdata); else n_pass++;
      n_total++; if ({rt_grant, rt_ready, ap_ready} !== 3'b000) $display("FAIL apw_rt_waits got %b exp 000", {rt_grant, rt_ready, ap_ready}); else n_pass++;
    end
    step(); // K+4
    n_total++; if ({ap_ready, mem_addr} !== {1'b1, 32'h200}) $display("FAIL apw_ready got %b/%h exp 1/00000200", ap_ready, mem_addr); else n_pass++;
    ap_en = 1'b0;
    step(); // K+5
    n_total++; if ({mem_en, rt_grant} !== 2'b00) $display("FAIL apw_turnaround got %b exp 00", {mem_en, rt_grant}); else n_pass++;
    step(); // K+6
    n_total++; if ({rt_grant, mem_addr} !== {1'b1, 32'h300}) $display("FAIL apw_rt_granted got %b/%h exp 1/00000300", rt_grant, mem_addr); else n_pass++;
    for (int i = 0; i < 10 && !got; i++) begin
      if (rt_ready) got = 1'b1; else step();
    end
    n_total++; if (got !== 1'b1) $display("FAIL apw_rt_done got %b exp 1 (cycle budget)", got); else n_pass++;
    rt_en = 1'b0;
    step();
  endtask

  task automatic test_drop_en();
    mem_lat = 4'd2;
    rt_en = 1'b1; rt_addr = 32'h500;
    step();
    ap_en = 1'b1; ap_addr = 32'h600;
    step();
    ap_en = 1'b0;
    step();
    n_total++; if (rt_ready !== 1'b1) $display("FAIL drop_rt_ready got %b exp 1", rt_ready); else n_pass++;
    rt_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_total++; if ({ap_grant, mem_en} !== 2'b00) $display("FAIL drop_no_grant got %b exp 00", {ap_grant, mem_en}); else n_pass++;
    end
    n_total++; if (dut.ap_wait_cnt !== 3'd0) $display("FAIL drop_wait_cnt got %0d exp 0", dut.ap_wait_cnt); else n_pass++;
  endtask

  task automatic test_idle_ready();
    rd_val = 32'h7777_7777;
    ready_force = 1'b1;
    #1;
    n_total++; if ({rt_ready, ap_ready} !== 2'b00) $display("FAIL idle_ready_leak got %b exp 00", {rt_ready, ap_ready}); else n_pass++;
    n_total++; if ({rt_rdata, ap_rdata} !== 64'h0) $display("FAIL idle_rdata_leak got %h/%h exp 0/0", rt_rdata, ap_rdata); else n_pass++;
    step();
    n_total++; if ({mem_en, rt_grant, ap_grant} !== 3'b000) $display("FAIL idle_ready_ignored got %b exp 000", {mem_en, rt_grant, ap_grant}); else n_pass++;
    ready_force = 1'b0;
    step();
  endtask

  task automatic test_reset_midgrant();
    mem_lat = 4'd5;
    rt_en = 1'b1; rt_addr = 32'h700; ap_en = 1'b1; ap_addr = 32'h800;
    step();
    n_total++; if ({rt_grant, dut.ap_wait_cnt} !== {1'b1, 3'd1}) $display("FAIL rstmid_pre got %b/%0d exp 1/1", rt_grant, dut.ap_wait_cnt); else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_total++; if ({mem_en, rt_ready, rt_grant} !== 3'b000) $display("FAIL rstmid_async got %b exp 000", {mem_en, rt_ready, rt_grant}); else n_pass++;
    n_total++; if (dut.ap_wait_cnt !== 3'd0) $display("FAIL rstmid_wait_cnt got %0d exp 0", dut.ap_wait_cnt); else n_pass++;
    rt_en = 1'b0; ap_en = 1'b0;
    #1 rst_n = 1'b1;
    step();
    n_total++; if ({mem_en, rt_grant, ap_grant} !== 3'b000) $display("FAIL rstmid_idle got %b exp 000", {mem_en, rt_grant, ap_grant}); else n_pass++;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst_n = 1'b0; rt_en = 1'b0; rt_we = 1'b0; rt_addr = '0; rt_wdata = '0;
    ap_en = 1'b0; ap_we = 1'b0; ap_addr = '0; ap_wdata = '0;
    mem_lat = 4'd0; rd_val = '0; ready_force = 1'b0;
    test_reset();
    test_rt_read();
    test_simultaneous();
    test_starvation();
    test_ap_write_inflight();
    test_drop_en();
    test_idle_ready();
    test_reset_midgrant();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
